// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage, with the HI/LO registers.
// Each operation takes WIDTH busy cycles. MULT/MULTU leave {HI,LO} = product.
// DIV/DIVU leave LO = quotient and HI = remainder.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Rs_data,
  input  logic [WIDTH-1:0] Rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned AW    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [AW-1:0]    acc_q;
  logic [WIDTH-1:0] opb_q;
  logic             is_div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             b_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_nxt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [AW-1:0]    div_nxt;
  logic [AW-1:0]    acc_nxt;
  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             last_step;

  // Operand magnitudes and signs for signed ops (op[0] = signed).
  always_comb begin
    a_neg = op[0] & Rs_data[WIDTH-1];
    b_neg = op[0] & Rt_data[WIDTH-1];
    a_abs = a_neg ? -Rs_data : Rs_data;
    b_abs = b_neg ? -Rt_data : Rt_data;
  end

  // One iteration step: shift-add multiply or restoring divide over acc_q.
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[AW-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, opb_q};
    div_ok   = ~div_diff[WIDTH];
    div_nxt  = {(div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};
    acc_nxt  = is_div_q ? div_nxt : mul_nxt;
  end

  // Sign correction of the final step and the divide-by-zero override.
  always_comb begin
    prod = neg_lo_q ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[WIDTH-1:0];
    rem  = acc_nxt[AW-1:WIDTH];
    if (is_div_q) begin
      res_lo = b_zero_q ? '1 : (neg_lo_q ? -quo : quo);
      res_hi = neg_hi_q ? -rem : rem;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[AW-1:WIDTH];
    end
  end

  assign last_step = (count_q == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, and HI/LO updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q  <= '0;
            is_div_q <= op[1];
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= op[1] & a_neg;
            b_zero_q <= (Rt_data == '0);
            acc_q    <= op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
            opb_q    <= op[1] ? b_abs : a_abs;
          end else begin
            if (hi_we) hi_q <= Rs_data;
            if (lo_we) lo_q <= Rs_data;
          end
        end
        S_BUSY: begin
          acc_q   <= acc_nxt;
          count_q <= count_q + CNT_W'(1);
          if (last_step) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall  = ((state_q == S_IDLE) && start) || (state_q == S_BUSY);
  assign busy   = (state_q == S_BUSY);
  assign done   = (state_q == S_DONE);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] Rs_data, Rt_data;
  logic         hi_we, lo_we;
  logic         stall, busy, done;
  logic [W-1:0] hi_out, lo_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .Rs_data(Rs_data), .Rt_data(Rt_data), .hi_we(hi_we), .lo_we(lo_we),
    .stall(stall), .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an op with start held until done. Operands are scrambled mid-BUSY.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic mv,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int stalls;
    bit seen;
    stalls = 0;
    seen   = 0;
    op = o; Rs_data = a; Rt_data = b; start = 1'b1; hi_we = mv; lo_we = mv;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done) begin
        seen = 1;
        break;
      end
      if (stall) stalls++;
      if (i == 5) begin
        Rs_data = ~a;
        Rt_data = ~b;
      end
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, "_stall_cycles"}, 64'(stalls), 64'(W + 1));
    check_eq({tag, "_stall_at_done"}, 64'(stall), 64'd0);
    check_eq({tag, "_hi"}, 64'(hi_out), 64'(eh));
    check_eq({tag, "_lo"}, 64'(lo_out), 64'(el));
  endtask

  task automatic idle_cycle(input string tag);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    tick();
    check_eq({tag, "_done_pulse_end"}, 64'(done), 64'd0);
    check_eq({tag, "_idle_stall"}, 64'(stall), 64'd0);
    check_eq({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; op = 2'b00; Rs_data = '0; Rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi_out), 64'd0);
    check_eq("rst_lo", 64'(lo_out), 64'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    idle_cycle("multu_max");
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    idle_cycle("mult_m3x7");
    run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    idle_cycle("div_m7d2");
    run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD);
    idle_cycle("div_7dm2");
    run_op("div_m7dm2", OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'd3);
    idle_cycle("div_m7dm2");
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 1'b0, 32'h0000_0064, 32'hFFFF_FFFF);
    idle_cycle("divu_by0");
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
    idle_cycle("div_ovf");
    run_op("div_m5by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    idle_cycle("div_m5by0");
    run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'd0);
    idle_cycle("mult_minsq");
    run_op("divu_max16", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b0, 32'd15, 32'h0FFF_FFFF);
    idle_cycle("divu_max16");

    // start held through DONE, then a back-to-back op
    run_op("held", OP_MULTU, 32'd3, 32'd5, 1'b0, 32'd0, 32'd15);
    tick();
    check_eq("held_no_second_done", 64'(done), 64'd0);
    check_eq("held_idle_busy", 64'(busy), 64'd0);
    check_eq("b2b_stall_reassert", 64'(stall), 64'd1);
    run_op("b2b", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
    idle_cycle("b2b");

    // reset mid-operation at count 10
    op = OP_MULTU; Rs_data = 32'hFFFF_FFFF; Rt_data = 32'hFFFF_FFFF; start = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check_eq("rstmid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1; start = 1'b0;
    tick();
    check_eq("rstmid_stall", 64'(stall), 64'd0);
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_hi", 64'(hi_out), 64'd0);
    check_eq("rstmid_lo", 64'(lo_out), 64'd0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    check_eq("rstmid_no_done", 64'(dones), 64'd0);
    check_eq("rstmid_hi_after", 64'(hi_out), 64'd0);

    // HI/LO moves in IDLE, ignored while BUSY
    Rs_data = 32'h1234_5678; hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    check_eq("mthi", 64'(hi_out), 64'h1234_5678);
    check_eq("mthi_lo_untouched", 64'(lo_out), 64'd0);
    Rs_data = 32'hCAFE_F00D; lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    check_eq("mtlo", 64'(lo_out), 64'hCAFE_F00D);
    op = OP_MULTU; Rs_data = 32'd2; Rt_data = 32'd3; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
    tick(); tick();
    check_eq("mv_busy_state", 64'(busy), 64'd1);
    check_eq("mv_busy_hi", 64'(hi_out), 64'h1234_5678);
    check_eq("mv_busy_lo", 64'(lo_out), 64'hCAFE_F00D);
    dones = 0;
    for (int i = 0; i < 40 && dones == 0; i++) begin
      tick();
      if (done) dones++;
    end
    check_eq("mv_done", 64'(dones), 64'd1);
    check_eq("mv_res_hi", 64'(hi_out), 64'd0);
    check_eq("mv_res_lo", 64'(lo_out), 64'd6);
    idle_cycle("mv");
    check_eq("mv_after_hi", 64'(hi_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
